// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bridging the core memory stage to the shared system bus:
// slave decode, alignment checks, lane steering, grant handshake with timeout.
module lsu_bus_ctrl #(
  parameter int N_SLAVES          = 4,
  parameter int REGIONS_PER_SLAVE = 2,
  parameter int TIMEOUT           = 16
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  input  logic                i_REQ,
  input  logic                i_WE,
  input  logic                i_RE,
  input  logic [1:0]          i_HB,
  input  logic                i_UNS,
  input  logic [31:0]         i_ADDR,
  input  logic [31:0]         i_WDATA,
  output logic [31:0]         o_RDATA,
  output logic                o_BUSY,
  output logic                o_DONE,
  output logic                o_FAULT,
  output logic [1:0]          o_FAULT_CAUSE,
  input  logic [31:0]         i_BUS_RDATA,
  output logic [31:0]         o_BUS_WDATA,
  output logic [31:0]         o_BUS_ADDR,
  output logic                o_BUS_WE,
  output logic                o_BUS_RE,
  output logic [1:0]          o_BUS_HB,
  output logic [3:0]          o_BUS_BE,
  output logic [N_SLAVES-1:0] o_BUS_CE,
  output logic                o_BUS_REQ,
  input  logic                i_BUS_GNT
);

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [4:0] RPS = 5'(REGIONS_PER_SLAVE);
  localparam logic [4:0] NSL = 5'(N_SLAVES);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       lsb_q;
  logic             uns_q;
  logic             load_q;

  logic [4:0]          slv_idx;
  logic                mapped;
  logic                misalign;
  logic                accept;
  logic [N_SLAVES-1:0] ce_dec;
  logic [3:0]          be_dec;
  logic [31:0]         wdata_rep;
  logic [1:0]          cause_dec;

  // Pick the addressed byte/half from the bus word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] lsb,
                                           input logic [1:0] hb, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lsb)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lsb[1] ? rd[31:16] : rd[15:0];
    case (hb)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  always_comb begin
    slv_idx  = {1'b0, i_ADDR[31:28]} / RPS;
    mapped   = (slv_idx < NSL);
    ce_dec   = '0;
    if (mapped) ce_dec = N_SLAVES'(1) << slv_idx;
    misalign = (i_HB == 2'b11) || (i_HB == 2'b01 && i_ADDR[0]) ||
               (i_HB == 2'b10 && i_ADDR[1:0] != 2'b00);
    case (i_HB)
      2'b00: begin
        be_dec    = 4'b0001 << i_ADDR[1:0];
        wdata_rep = {4{i_WDATA[7:0]}};
      end
      2'b01: begin
        be_dec    = 4'b0011 << i_ADDR[1:0];
        wdata_rep = {2{i_WDATA[15:0]}};
      end
      default: begin
        be_dec    = 4'b1111;
        wdata_rep = i_WDATA;
      end
    endcase
    if (i_WE && i_RE)  cause_dec = 2'b10;
    else if (misalign) cause_dec = 2'b01;
    else if (!mapped)  cause_dec = 2'b10;
    else               cause_dec = 2'b00;
    accept = (state == IDLE) && i_REQ && (i_WE || i_RE);
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state         <= IDLE;
      cnt           <= '0;
      lsb_q         <= '0;
      uns_q         <= 1'b0;
      load_q        <= 1'b0;
      o_RDATA       <= '0;
      o_BUSY        <= 1'b0;
      o_DONE        <= 1'b0;
      o_FAULT       <= 1'b0;
      o_FAULT_CAUSE <= '0;
      o_BUS_WDATA   <= '0;
      o_BUS_ADDR    <= '0;
      o_BUS_WE      <= 1'b0;
      o_BUS_RE      <= 1'b0;
      o_BUS_HB      <= '0;
      o_BUS_BE      <= '0;
      o_BUS_CE      <= '0;
      o_BUS_REQ     <= 1'b0;
    end else begin
      o_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            o_BUSY <= 1'b1;
            lsb_q  <= i_ADDR[1:0];
            uns_q  <= i_UNS;
            load_q <= i_RE;
            if (cause_dec != 2'b00) begin
              // Faulting access goes straight to the response, bus untouched.
              state         <= RESP;
              o_DONE        <= 1'b1;
              o_FAULT       <= 1'b1;
              o_FAULT_CAUSE <= cause_dec;
              o_RDATA       <= '0;
            end else begin
              state       <= WAIT_GNT;
              cnt         <= '0;
              o_BUS_REQ   <= 1'b1;
              o_BUS_WE    <= i_WE;
              o_BUS_RE    <= i_RE;
              o_BUS_HB    <= i_HB;
              o_BUS_BE    <= be_dec;
              o_BUS_CE    <= ce_dec;
              o_BUS_ADDR  <= {4'h0, i_ADDR[27:0]};
              o_BUS_WDATA <= wdata_rep;
            end
          end
        end
        WAIT_GNT: begin
          if (i_BUS_GNT || (TO_EN && cnt == CNT_LAST)) begin
            state         <= RESP;
            o_DONE        <= 1'b1;
            o_FAULT       <= !i_BUS_GNT;
            o_FAULT_CAUSE <= i_BUS_GNT ? 2'b00 : 2'b11;
            o_RDATA       <= (i_BUS_GNT && load_q) ?
                             load_ext(i_BUS_RDATA, lsb_q, o_BUS_HB, uns_q) : 32'h0;
            o_BUS_REQ     <= 1'b0;
            o_BUS_WE      <= 1'b0;
            o_BUS_RE      <= 1'b0;
            o_BUS_BE      <= '0;
            o_BUS_CE      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          state         <= IDLE;
          o_BUSY        <= 1'b0;
          o_FAULT       <= 1'b0;
          o_FAULT_CAUSE <= '0;
          o_RDATA       <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
